deco_n_seq: RTL and testbench

DECO_N_SEQ -- requirements
Module: deco_n_seq

---
 rtl/deco_n_seq.sv | 131 +++++++++++++
 tb/tb_deco_n_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/deco_n_seq.sv
// N-to-2**N decoder with direct, latched, thermometer and scanning modes.
// All outputs except in_ready are registered; the scan can be frozen with en and resumed.
module deco_n_seq #(
    parameter int N          = 3,
    parameter int STEP       = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                in_valid,
    input  logic [N-1:0]        in_sel,
    output logic                in_ready,
    output logic [(2**N)-1:0]   out,
    output logic                out_valid,
    output logic [N-1:0]        scan_idx,
    output logic                wrap
);

    localparam int OUT_W = 2 ** N;
    localparam int DW    = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(STEP - 1);

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_SCAN   = 2'b10;
    localparam logic [1:0] M_THERMO = 2'b11;

    typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_out;
    logic             r_out_valid;
    logic [N-1:0]     r_scan_idx;
    logic [DW-1:0]    r_dwell;
    logic             r_wrap;
    logic             r_scan_susp;

    logic             w_scan_mode;
    logic             w_accept;
    logic [N-1:0]     w_idx_next;

    function automatic logic [OUT_W-1:0] f_onehot(input logic [N-1:0] s);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] f_thermo(input logic [N-1:0] s);
        logic [OUT_W-1:0] v;
        for (int i = 0; i < OUT_W; i++) begin
            v[i] = (i <= int'(s));
        end
        return v;
    endfunction

    assign w_scan_mode = (mode == M_SCAN);
    assign in_ready    = (r_state == DECODE) && en && !w_scan_mode;
    assign w_accept    = in_valid && in_ready;
    assign w_idx_next  = r_scan_idx + 1'b1;

    // r_scan_susp remembers that en dropped while scanning, so re-enabling resumes instead of restarting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_scan_idx  <= '0;
            r_dwell     <= '0;
            r_wrap      <= 1'b0;
            r_scan_susp <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                if (r_state != IDLE) begin
                    r_scan_susp <= (r_state == SCAN);
                end
            end else if (w_scan_mode) begin
                r_state     <= SCAN;
                r_scan_susp <= 1'b0;
                if (r_state == SCAN) begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell    <= '0;
                        r_scan_idx <= w_idx_next;
                        r_out      <= f_onehot(w_idx_next);
                        r_wrap     <= (r_scan_idx == '1);
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end else if ((r_state == DECODE) || !r_scan_susp) begin
                    r_scan_idx  <= '0;
                    r_dwell     <= '0;
                    r_out       <= f_onehot('0);
                    r_out_valid <= 1'b1;
                end
            end else begin
                r_state     <= DECODE;
                r_scan_susp <= 1'b0;
                if (r_state == DECODE) begin
                    case (mode)
                        M_DIRECT: begin
                            r_out       <= w_accept ? f_onehot(in_sel) : '0;
                            r_out_valid <= w_accept;
                        end
                        M_THERMO: begin
                            if (w_accept) begin
                                r_out       <= f_thermo(in_sel);
                                r_out_valid <= 1'b1;
                            end
                        end
                        default: begin
                            // LATCH: update on accept, hold otherwise
                            if (w_accept) begin
                                r_out       <= f_onehot(in_sel);
                                r_out_valid <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign out       = ACTIVE_LOW ? ~r_out : r_out;
    assign out_valid = r_out_valid;
    assign scan_idx  = r_scan_idx;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_deco_n_seq.sv
// Directed bench for deco_n_seq: main N=3/STEP=4 instance plus active-low and N=1/STEP=1 variants.
module tb_deco_n_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [2:0] in_sel;

    logic       in_ready, out_valid, wrap;
    logic [7:0] out;
    logic [2:0] scan_idx;

    logic       in_ready_al, out_valid_al, wrap_al;
    logic [7:0] out_al;
    logic [2:0] scan_idx_al;

    logic       in_ready_n1, out_valid_n1, wrap_n1;
    logic [1:0] out_n1;
    logic [0:0] scan_idx_n1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deco_n_seq #(.N(3), .STEP(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .scan_idx(scan_idx), .wrap(wrap)
    );

    deco_n_seq #(.N(3), .STEP(4), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel),
        .in_ready(in_ready_al), .out(out_al), .out_valid(out_valid_al), .scan_idx(scan_idx_al),
        .wrap(wrap_al)
    );

    deco_n_seq #(.N(1), .STEP(1), .ACTIVE_LOW(1'b0)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid), .in_sel(in_sel[0]),
        .in_ready(in_ready_n1), .out(out_n1), .out_valid(out_valid_n1), .scan_idx(scan_idx_n1),
        .wrap(wrap_n1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; in_valid = 1'b0; in_sel = 3'd0;
        #3;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want %h", out, 8'h00); end
        checks++; if (out_al !== 8'hFF) begin errors++; $display("FAIL reset_out_al: got %h want %h", out_al, 8'hFF); end
        checks++; if (out_valid !== 1'b0 || out_valid_al !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b want 0/0", out_valid, out_valid_al); end
        checks++; if (scan_idx !== 3'd0 || scan_idx_al !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d/%0d want 0", scan_idx, scan_idx_al); end
        checks++; if (wrap !== 1'b0 || wrap_al !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b/%b want 0", wrap, wrap_al); end
        checks++; if (in_ready !== 1'b0 || in_ready_al !== 1'b0 || in_ready_n1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b%b want 000", in_ready, in_ready_al, in_ready_n1); end
        step(); step();
        #2 rst_n = 1'b1;
        step();
        checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %h/%b want 00/0", out, out_valid); end
    endtask

    task automatic test_direct();
        mode = 2'b00; en = 1'b1;
        step();
        in_valid = 1'b1; in_sel = 3'd5;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL direct_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out !== 8'b0010_0000 || out_valid !== 1'b1) begin errors++; $display("FAIL direct_sel5: got %h/%b want 20/1", out, out_valid); end
        in_sel = 3'd1;
        step();
        checks++; if (out !== 8'h02 || out_valid !== 1'b1) begin errors++; $display("FAIL direct_b2b_1: got %h/%b want 02/1", out, out_valid); end
        in_sel = 3'd2;
        step();
        checks++; if (out !== 8'h04 || out_valid !== 1'b1) begin errors++; $display("FAIL direct_b2b_2: got %h/%b want 04/1", out, out_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (out !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL direct_clear: got %h/%b want 00/0", out, out_valid); end
    endtask

    task automatic test_latch();
        mode = 2'b01; in_valid = 1'b1; in_sel = 3'd2;
        step();
        checks++; if (out !== 8'b0000_0100 || out_valid !== 1'b1) begin errors++; $display("FAIL latch_accept: got %h/%b want 04/1", out, out_valid); end
        in_valid = 1'b0; in_sel = 3'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (out !== 8'h04 || out_valid !== 1'b1) begin errors++; $display("FAIL latch_hold%0d: got %h/%b want 04/1", i, out, out_valid); end
        end
        in_valid = 1'b1; in_sel = 3'd6;
        step();
        checks++; if (out !== 8'h40) begin errors++; $display("FAIL latch_update: got %h want 40", out); end
        in_valid = 1'b0;
    endtask

    task automatic test_thermo();
        mode = 2'b11; in_valid = 1'b1; in_sel = 3'd3;
        step();
        checks++; if (out !== 8'b0000_1111 || out_valid !== 1'b1) begin errors++; $display("FAIL thermo_3: got %h/%b want 0f/1", out, out_valid); end
        in_sel = 3'd7;
        step();
        checks++; if (out !== 8'hFF) begin errors++; $display("FAIL thermo_7: got %h want ff", out); end
        checks++; if (out_al !== 8'h00) begin errors++; $display("FAIL thermo_7_al: got %h want 00", out_al); end
        in_sel = 3'd0;
        step();
        checks++; if (out !== 8'h01) begin errors++; $display("FAIL thermo_0: got %h want 01", out); end
        in_valid = 1'b0; in_sel = 3'd5;
        step();
        checks++; if (out !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL thermo_hold: got %h/%b want 01/1", out, out_valid); end
    endtask

    task automatic test_scan();
        int         wraps;
        logic [2:0] e_idx;
        logic [7:0] e_out;
        logic       e_n1;
        wraps = 0;
        mode = 2'b10; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL scan_ready_pre: got %b want 0", in_ready); end
        step();
        for (int k = 0; k < 36; k++) begin
            e_idx = 3'((k / 4) % 8);
            e_out = 8'h01 << e_idx;
            e_n1  = 1'(k % 2);
            if (wrap === 1'b1) wraps++;
            checks++; if (scan_idx !== e_idx || out !== e_out || out_valid !== 1'b1) begin errors++; $display("FAIL scan_k%0d: got idx %0d out %h v %b want idx %0d out %h v 1", k, scan_idx, out, out_valid, e_idx, e_out); end
            checks++; if (out_al !== ~e_out) begin errors++; $display("FAIL scan_al_k%0d: got %h want %h", k, out_al, ~e_out); end
            checks++; if (wrap !== (k == 32) || in_ready !== 1'b0) begin errors++; $display("FAIL scan_wrap_k%0d: got wrap %b ready %b want %b/0", k, wrap, in_ready, (k == 32)); end
            checks++; if (scan_idx_n1 !== e_n1 || out_n1 !== (2'b01 << e_n1) || wrap_n1 !== (k > 0 && e_n1 == 1'b0)) begin errors++; $display("FAIL scan_n1_k%0d: got idx %0d out %b wrap %b want idx %0d", k, scan_idx_n1, out_n1, wrap_n1, e_n1); end
            step();
        end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL scan_wrap_count: got %0d want 1", wraps); end
        in_valid = 1'b0;
    endtask

    task automatic test_freeze();
        mode = 2'b00;
        step();
        mode = 2'b10;
        step();
        repeat (25) step();
        checks++; if (scan_idx !== 3'd6) begin errors++; $display("FAIL freeze_start: got %0d want 6", scan_idx); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (scan_idx !== 3'd6 || out !== 8'h40 || out_valid !== 1'b1 || wrap !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL freeze_%0d: got idx %0d out %h v %b w %b r %b want 6/40/1/0/0", i, scan_idx, out, out_valid, wrap, in_ready); end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (scan_idx !== 3'd6) begin errors++; $display("FAIL resume_hold%0d: got %0d want 6", i, scan_idx); end
        end
        step();
        checks++; if (scan_idx !== 3'd7 || out !== 8'h80) begin errors++; $display("FAIL resume_adv: got %0d/%h want 7/80", scan_idx, out); end
    endtask

    task automatic test_async_reset();
        mode = 2'b00;
        step();
        mode = 2'b10;
        step();
        repeat (16) step();
        checks++; if (scan_idx !== 3'd4) begin errors++; $display("FAIL areset_pre: got %0d want 4", scan_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0) begin errors++; $display("FAIL areset_main: got %h/%b/%0d want 00/0/0", out, out_valid, scan_idx); end
        checks++; if (out_al !== 8'hFF || out_valid_al !== 1'b0 || scan_idx_al !== 3'd0) begin errors++; $display("FAIL areset_al: got %h/%b/%0d want ff/0/0", out_al, out_valid_al, scan_idx_al); end
        checks++; if (wrap !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL areset_ctl: got %b/%b want 0/0", wrap, in_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++; if (scan_idx !== 3'd0 || out !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL areset_restart: got %0d/%h/%b want 0/01/1", scan_idx, out, out_valid); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_latch();
        test_thermo();
        test_scan();
        test_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
